// File: rtl/cam_tcam_engine.sv
// cam_tcam_engine: ternary CAM lookup engine.
// Each entry holds a value, a care mask and a valid bit. A lookup reports the lowest
// hitting index and a multi-hit flag two cycles after the request. Writes, deletes and
// flushes go through a small FSM that raises BUSY while it owns the table.
// Optional feature macro: CAM_HIT_STATS_EN builds saturating lookup/hit counters;
// without it LOOKUP_CNT/HIT_CNT are tied to zero and STATS_CLR is ignored.
module cam_tcam_engine #(
    parameter int C_WIDTH   = 205,
    parameter int C_DEPTH   = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMP_VALID,
    input  logic [C_WIDTH-1:0]   CMP_DIN,
    output logic                 MATCH_VALID,
    output logic                 MATCH,
    output logic                 MATCH_MULTI,
    output logic [ADDR_BITS-1:0] MATCH_ADDR,
    input  logic                 WE,
    input  logic [ADDR_BITS-1:0] WR_ADDR,
    input  logic                 WR_DELETE,
    input  logic [C_WIDTH-1:0]   DIN,
    input  logic [C_WIDTH-1:0]   DIN_MASK,
    input  logic                 FLUSH,
    output logic                 BUSY,
    output logic [31:0]          LOOKUP_CNT,
    output logic [31:0]          HIT_CNT,
    input  logic                 STATS_CLR
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FLUSH} state_t;

    // Lowest set bit wins; returns 0 when no bit is set.
    function automatic logic [ADDR_BITS-1:0] prio_addr(input logic [C_DEPTH-1:0] hits);
        logic [ADDR_BITS-1:0] a;
        a = '0;
        for (int i = C_DEPTH - 1; i >= 0; i--) begin
            if (hits[i]) a = ADDR_BITS'(i);
        end
        return a;
    endfunction

    // True when two or more bits are set: clearing the lowest set bit leaves something.
    function automatic logic multi_hit(input logic [C_DEPTH-1:0] hits);
        return |(hits & (hits - C_DEPTH'(1)));
    endfunction

    state_t               r_state, w_state_nxt;
    logic                 r_busy;
    logic [ADDR_BITS-1:0] r_flush_idx;
    logic                 w_accept_write, w_accept_flush, w_commit, w_flush_step;

    logic [ADDR_BITS-1:0] r_wr_addr;
    logic                 r_wr_delete;
    logic [C_WIDTH-1:0]   r_wr_value, r_wr_mask;

    logic [C_WIDTH-1:0]   r_value [C_DEPTH];
    logic [C_WIDTH-1:0]   r_mask  [C_DEPTH];
    logic [C_DEPTH-1:0]   r_valid;

    logic                 r_vld_p1;
    logic [C_WIDTH-1:0]   r_key_p1;
    logic [C_DEPTH-1:0]   w_hit;
    logic                 r_vld_p2, r_match_p2, r_multi_p2;
    logic [ADDR_BITS-1:0] r_addr_p2;

    // FSM state and registered BUSY (high whenever the next state owns the table).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next state; FLUSH beats WE when both arrive together, and the write is lost.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept_write = 1'b0;
        w_accept_flush = 1'b0;
        w_commit       = 1'b0;
        w_flush_step   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (FLUSH) begin
                    w_state_nxt    = ST_FLUSH;
                    w_accept_flush = 1'b1;
                end else if (WE) begin
                    w_state_nxt    = ST_WRITE;
                    w_accept_write = 1'b1;
                end
            end
            ST_WRITE: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_FLUSH: begin
                w_flush_step = 1'b1;
                if (r_flush_idx == ADDR_BITS'(C_DEPTH - 1)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Flush walks the table one index per cycle starting at 0.
    always_ff @(posedge CLK) begin
        if (RST)                 r_flush_idx <= '0;
        else if (w_accept_flush) r_flush_idx <= '0;
        else if (w_flush_step)   r_flush_idx <= r_flush_idx + 1'b1;
    end

    // Capture the accepted write request so the requester may change its inputs.
    always_ff @(posedge CLK) begin
        if (w_accept_write) begin
            r_wr_addr   <= WR_ADDR;
            r_wr_delete <= WR_DELETE;
            r_wr_value  <= DIN;
            r_wr_mask   <= DIN_MASK;
        end
    end

    // Entry valid bits; an address beyond the table matches no index and is a no-op.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < C_DEPTH; i++) begin
                if (w_commit && r_wr_addr == ADDR_BITS'(i)) r_valid[i] <= !r_wr_delete;
                if (w_flush_step && r_flush_idx == ADDR_BITS'(i)) r_valid[i] <= 1'b0;
            end
        end
    end

    // Entry value/mask storage, only touched by a committed (non-delete) write.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < C_DEPTH; i++) begin
            if (w_commit && !r_wr_delete && r_wr_addr == ADDR_BITS'(i)) begin
                r_value[i] <= r_wr_value;
                r_mask[i]  <= r_wr_mask;
            end
        end
    end

    // Stage 1 control: lookup valid.
    always_ff @(posedge CLK) begin
        if (RST) r_vld_p1 <= 1'b0;
        else     r_vld_p1 <= CMP_VALID;
    end

    // Stage 1 data: lookup key.
    always_ff @(posedge CLK) begin
        r_key_p1 <= CMP_DIN;
    end

    // Per-entry ternary compare against the current table contents.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < C_DEPTH; i++) begin
            w_hit[i] = r_valid[i] && (((r_key_p1 ^ r_value[i]) & r_mask[i]) == '0);
        end
    end

    // Stage 2: encoded result; data holds its last value when no lookup completes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld_p2   <= 1'b0;
            r_match_p2 <= 1'b0;
            r_multi_p2 <= 1'b0;
            r_addr_p2  <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_match_p2 <= |w_hit;
                r_multi_p2 <= multi_hit(w_hit);
                r_addr_p2  <= prio_addr(w_hit);
            end
        end
    end

    assign MATCH_VALID = r_vld_p2;
    assign MATCH       = r_match_p2;
    assign MATCH_MULTI = r_multi_p2;
    assign MATCH_ADDR  = r_addr_p2;
    assign BUSY        = r_busy;

`ifdef CAM_HIT_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_lookup_cnt, r_hit_cnt;

    // Saturating statistics; a clear wins over an increment in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST || STATS_CLR) begin
            r_lookup_cnt <= '0;
            r_hit_cnt    <= '0;
        end else begin
            if (CMP_VALID) r_lookup_cnt <= sat_inc(r_lookup_cnt);
            if (r_vld_p2 && r_match_p2) r_hit_cnt <= sat_inc(r_hit_cnt);
        end
    end

    assign LOOKUP_CNT = r_lookup_cnt;
    assign HIT_CNT    = r_hit_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = STATS_CLR;
    assign LOOKUP_CNT     = '0;
    assign HIT_CNT        = '0;
`endif

endmodule

// File: tb/tb_cam_tcam_engine.sv
// Directed testbench for cam_tcam_engine: a 16-entry instance (a_*) and a 12-entry
// instance (b_*) sharing one clock. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_cam_tcam_engine;

    localparam int C_W = 205;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic           a_rst, a_cmp_valid, a_we, a_del, a_flush, a_clr;
    logic [C_W-1:0] a_cmp_din, a_din, a_mask;
    logic [3:0]     a_wr_addr;
    logic           a_match_valid, a_match, a_match_multi, a_busy;
    logic [3:0]     a_match_addr;
    logic [31:0]    a_lookup_cnt, a_hit_cnt;

    logic           b_rst, b_cmp_valid, b_we, b_del, b_flush, b_clr;
    logic [C_W-1:0] b_cmp_din, b_din, b_mask;
    logic [3:0]     b_wr_addr;
    logic           b_match_valid, b_match, b_match_multi, b_busy;
    logic [3:0]     b_match_addr;
    logic [31:0]    b_lookup_cnt, b_hit_cnt;

    localparam logic [C_W-1:0] ONES  = {C_W{1'b1}};
    localparam logic [C_W-1:0] MASK7 = {{(C_W-8){1'b1}}, 8'hF0};

    cam_tcam_engine #(.C_WIDTH(C_W), .C_DEPTH(16), .ADDR_BITS(4)) dut_a (
        .CLK(clk), .RST(a_rst), .CMP_VALID(a_cmp_valid), .CMP_DIN(a_cmp_din),
        .MATCH_VALID(a_match_valid), .MATCH(a_match), .MATCH_MULTI(a_match_multi),
        .MATCH_ADDR(a_match_addr), .WE(a_we), .WR_ADDR(a_wr_addr), .WR_DELETE(a_del),
        .DIN(a_din), .DIN_MASK(a_mask), .FLUSH(a_flush), .BUSY(a_busy),
        .LOOKUP_CNT(a_lookup_cnt), .HIT_CNT(a_hit_cnt), .STATS_CLR(a_clr)
    );

    cam_tcam_engine #(.C_WIDTH(C_W), .C_DEPTH(12), .ADDR_BITS(4)) dut_b (
        .CLK(clk), .RST(b_rst), .CMP_VALID(b_cmp_valid), .CMP_DIN(b_cmp_din),
        .MATCH_VALID(b_match_valid), .MATCH(b_match), .MATCH_MULTI(b_match_multi),
        .MATCH_ADDR(b_match_addr), .WE(b_we), .WR_ADDR(b_wr_addr), .WR_DELETE(b_del),
        .DIN(b_din), .DIN_MASK(b_mask), .FLUSH(b_flush), .BUSY(b_busy),
        .LOOKUP_CNT(b_lookup_cnt), .HIT_CNT(b_hit_cnt), .STATS_CLR(b_clr)
    );

    // obs = {MATCH_VALID one cycle after request, MATCH_VALID two cycles after,
    //        MATCH, MATCH_MULTI, MATCH_ADDR}
    task automatic lookup_a(input logic [C_W-1:0] key, output logic [7:0] obs);
        @(negedge clk); a_cmp_valid = 1'b1; a_cmp_din = key;
        @(negedge clk); a_cmp_valid = 1'b0; obs[7] = a_match_valid;
        @(negedge clk);
        obs[6] = a_match_valid; obs[5] = a_match; obs[4] = a_match_multi; obs[3:0] = a_match_addr;
    endtask

    task automatic lookup_b(input logic [C_W-1:0] key, output logic [7:0] obs);
        @(negedge clk); b_cmp_valid = 1'b1; b_cmp_din = key;
        @(negedge clk); b_cmp_valid = 1'b0; obs[7] = b_match_valid;
        @(negedge clk);
        obs[6] = b_match_valid; obs[5] = b_match; obs[4] = b_match_multi; obs[3:0] = b_match_addr;
    endtask

    task automatic write_a(input logic [3:0] addr, input logic del,
                           input logic [C_W-1:0] val, input logic [C_W-1:0] msk);
        @(negedge clk); a_we = 1'b1; a_wr_addr = addr; a_del = del; a_din = val; a_mask = msk;
        @(negedge clk); a_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_b(input logic [3:0] addr, input logic [C_W-1:0] val);
        @(negedge clk); b_we = 1'b1; b_wr_addr = addr; b_del = 1'b0; b_din = val; b_mask = ONES;
        @(negedge clk); b_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        a_cmp_valid = 0; a_we = 0; a_del = 0; a_flush = 0; a_clr = 0;
        a_cmp_din = '0; a_din = '0; a_mask = '0; a_wr_addr = '0;
        b_cmp_valid = 0; b_we = 0; b_del = 0; b_flush = 0; b_clr = 0;
        b_cmp_din = '0; b_din = '0; b_mask = '0; b_wr_addr = '0;
        repeat (3) @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_match_valid, a_match, a_match_multi, a_match_addr, a_busy} !== 8'b0)
            begin n_errors++; $display("FAIL reset_outputs got %b want 00000000",
                {a_match_valid, a_match, a_match_multi, a_match_addr, a_busy}); end
        n_checks++;
        if (a_lookup_cnt !== 32'd0 || a_hit_cnt !== 32'd0)
            begin n_errors++; $display("FAIL reset_counters got %0d/%0d want 0/0",
                a_lookup_cnt, a_hit_cnt); end
        n_checks++;
        if (b_busy !== 1'b0 || b_match_valid !== 1'b0)
            begin n_errors++; $display("FAIL reset_b got busy=%b mv=%b want 0/0",
                b_busy, b_match_valid); end
    endtask

    task automatic test_miss_latency();
        logic [7:0] obs;
        lookup_a(C_W'(8'h05), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b0, 1'b0, 4'd0})
            begin n_errors++; $display("FAIL empty_lookup_latency got %b want 01000000", obs); end
    endtask

    task automatic test_ternary_match();
        logic [7:0] obs;
        write_a(4'd3, 1'b0, C_W'(8'hAB), ONES);
        write_a(4'd7, 1'b0, C_W'(8'hA0), MASK7);
        lookup_a(C_W'(8'hAB), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b1, 1'b1, 4'd3})
            begin n_errors++; $display("FAIL key_AB_multi got %b want 01110011", obs); end
        lookup_a(C_W'(8'hA5), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b1, 1'b0, 4'd7})
            begin n_errors++; $display("FAIL key_A5_masked got %b want 01100111", obs); end
        lookup_a({1'b1, {(C_W-9){1'b0}}, 8'hAB}, obs);
        n_checks++;
        if (obs !== {2'b01, 1'b0, 1'b0, 4'd0})
            begin n_errors++; $display("FAIL key_top_bit_miss got %b want 01000000", obs); end
    endtask

    task automatic test_delete();
        logic [7:0] obs;
        write_a(4'd3, 1'b1, '0, '0);
        lookup_a(C_W'(8'hAB), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b1, 1'b0, 4'd7})
            begin n_errors++; $display("FAIL delete_then_AB got %b want 01100111", obs); end
    endtask

    task automatic test_busy_hold();
        logic [7:0] obs;
        @(negedge clk); a_we = 1'b1; a_wr_addr = 4'd5; a_del = 1'b0; a_din = C_W'(8'h11); a_mask = ONES;
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b1) begin n_errors++; $display("FAIL busy_rise got %b want 1", a_busy); end
        a_wr_addr = 4'd6; a_din = C_W'(8'h22);
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0) begin n_errors++; $display("FAIL busy_one_cycle got %b want 0", a_busy); end
        a_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0) begin n_errors++; $display("FAIL busy_stays_low got %b want 0", a_busy); end
        lookup_a(C_W'(8'h11), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b1, 1'b0, 4'd5})
            begin n_errors++; $display("FAIL first_write_committed got %b want 01100101", obs); end
        lookup_a(C_W'(8'h22), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b0, 1'b0, 4'd0})
            begin n_errors++; $display("FAIL busy_write_dropped got %b want 01000000", obs); end
    endtask

    task automatic test_flush_priority();
        logic [7:0] obs;
        int busy_cycles;
        busy_cycles = 0;
        @(negedge clk);
        a_flush = 1'b1; a_we = 1'b1; a_wr_addr = 4'd9; a_del = 1'b0; a_din = C_W'(8'h33); a_mask = ONES;
        @(negedge clk); a_flush = 1'b0; a_we = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (a_busy !== 1'b1) break;
            busy_cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (busy_cycles != 16)
            begin n_errors++; $display("FAIL flush_busy_cycles got %0d want 16", busy_cycles); end
        lookup_a(C_W'(8'h33), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b0, 1'b0, 4'd0})
            begin n_errors++; $display("FAIL flush_dropped_write got %b want 01000000", obs); end
        lookup_a(C_W'(8'hA5), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b0, 1'b0, 4'd0})
            begin n_errors++; $display("FAIL flush_entry7 got %b want 01000000", obs); end
        lookup_a(C_W'(8'h11), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b0, 1'b0, 4'd0})
            begin n_errors++; $display("FAIL flush_entry5 got %b want 01000000", obs); end
    endtask

    task automatic test_depth12_and_reset();
        logic [7:0] obs;
        write_b(4'd15, C_W'(8'h44));
        lookup_b(C_W'(8'h44), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b0, 1'b0, 4'd0})
            begin n_errors++; $display("FAIL out_of_range_write got %b want 01000000", obs); end
        write_b(4'd2, C_W'(8'h44));
        write_b(4'd10, C_W'(8'h55));
        lookup_b(C_W'(8'h55), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b1, 1'b0, 4'd10})
            begin n_errors++; $display("FAIL depth12_entry10 got %b want 01101010", obs); end
        @(negedge clk); b_flush = 1'b1;
        @(negedge clk); b_flush = 1'b0;
        n_checks++;
        if (b_busy !== 1'b1) begin n_errors++; $display("FAIL b_flush_busy got %b want 1", b_busy); end
        repeat (3) @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk); b_rst = 1'b0;
        n_checks++;
        if (b_busy !== 1'b0) begin n_errors++; $display("FAIL reset_mid_flush_busy got %b want 0", b_busy); end
        @(negedge clk);
        n_checks++;
        if (b_busy !== 1'b0) begin n_errors++; $display("FAIL reset_mid_flush_idle got %b want 0", b_busy); end
        lookup_b(C_W'(8'h55), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b0, 1'b0, 4'd0})
            begin n_errors++; $display("FAIL reset_mid_flush_entry10 got %b want 01000000", obs); end
        lookup_b(C_W'(8'h44), obs);
        n_checks++;
        if (obs !== {2'b01, 1'b0, 1'b0, 4'd0})
            begin n_errors++; $display("FAIL reset_mid_flush_entry2 got %b want 01000000", obs); end
    endtask

    task automatic test_stats();
        logic [7:0] obs;
        @(negedge clk); a_clr = 1'b1;
        @(negedge clk); a_clr = 1'b0;
        write_a(4'd1, 1'b0, C_W'(8'h77), ONES);
        for (int i = 0; i < 10; i++) lookup_a((i < 4) ? C_W'(8'h77) : C_W'(8'h78), obs);
        @(negedge clk);
`ifdef CAM_HIT_STATS_EN
        n_checks++;
        if (a_lookup_cnt !== 32'd10)
            begin n_errors++; $display("FAIL lookup_cnt got %0d want 10", a_lookup_cnt); end
        n_checks++;
        if (a_hit_cnt !== 32'd4)
            begin n_errors++; $display("FAIL hit_cnt got %0d want 4", a_hit_cnt); end
        @(negedge clk); a_clr = 1'b1; a_cmp_valid = 1'b1; a_cmp_din = C_W'(8'h77);
        @(negedge clk); a_clr = 1'b0; a_cmp_valid = 1'b0;
        n_checks++;
        if (a_lookup_cnt !== 32'd0 || a_hit_cnt !== 32'd0)
            begin n_errors++; $display("FAIL clr_priority got %0d/%0d want 0/0", a_lookup_cnt, a_hit_cnt); end
        repeat (3) @(negedge clk);
`else
        n_checks++;
        if (a_lookup_cnt !== 32'd0 || a_hit_cnt !== 32'd0)
            begin n_errors++; $display("FAIL stats_disabled got %0d/%0d want 0/0", a_lookup_cnt, a_hit_cnt); end
`endif
        n_checks++;
        if (obs !== {2'b01, 1'b0, 1'b0, 4'd0})
            begin n_errors++; $display("FAIL stats_last_miss got %b want 01000000", obs); end
    endtask

    initial begin
        test_reset();
        test_miss_latency();
        test_ternary_match();
        test_delete();
        test_busy_hold();
        test_flush_priority();
        test_depth12_and_reset();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
